// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one DRAM port between the fetch stage (f_*) and the
// vector memory controller (v_*). Round-robin arbitration, a single outstanding
// DRAM transaction, response routing back to the originator, and a sticky
// timeout flag for a DRAM that never answers.
//
// Handshake semantics: a request transfers on a rising edge where valid and
// ready are both high. Requesters hold valid and payload stable until they see
// ready; the arbiter holds m_req_* stable until m_req_ready. Responses are
// single-cycle pulses with no back-pressure.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 21,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_valid,
    input  logic              f_req_write,
    input  logic [ADDR_W-1:0] f_req_addr,
    input  logic [DATA_W-1:0] f_req_wdata,
    output logic              f_req_ready,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_rdata,
    input  logic              v_req_valid,
    input  logic              v_req_write,
    input  logic [ADDR_W-1:0] v_req_addr,
    input  logic [DATA_W-1:0] v_req_wdata,
    output logic              v_req_ready,
    output logic              v_rsp_valid,
    output logic [DATA_W-1:0] v_rsp_rdata,
    output logic              m_req_valid,
    output logic              m_req_write,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    input  logic              m_req_ready,
    input  logic              m_rsp_valid,
    input  logic [DATA_W-1:0] m_rsp_rdata,
    output logic              timeout_error,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The last WAIT cycle is the one in which the counter would reach the limit.
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    state_t              state;
    state_t              next_state;
    logic                owner_f;
    logic                owner_v;
    logic                last_grant_v;
    logic                req_write_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic                grant_f;
    logic                grant_v;
    logic                rsp_done;
    logic                timed_out;

    // Grant decision: a lone requester wins; on a tie the one not served last wins.
    // Gated by reset so every output reads 0 while reset is held.
    always_comb begin
        grant_f = 1'b0;
        grant_v = 1'b0;
        if (state == IDLE && !reset) begin
            grant_f = f_req_valid && (!v_req_valid || last_grant_v);
            grant_v = v_req_valid && (!f_req_valid || !last_grant_v);
        end
    end

    assign rsp_done  = (state == WAIT) && m_rsp_valid;
    // A response on the limit cycle takes priority over the timeout.
    assign timed_out = (state == WAIT) && !m_rsp_valid && (wait_cnt >= CNT_LAST);

    assign f_req_ready = grant_f;
    assign v_req_ready = grant_v;
    assign m_req_valid = (state == ISSUE);
    assign m_req_write = req_write_q;
    assign m_req_addr  = req_addr_q;
    assign m_req_wdata = req_wdata_q;
    assign state_dbg   = state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, issue until the DRAM takes it, then wait for an answer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_f || grant_v) next_state = ISSUE;
            ISSUE:   if (m_req_ready) next_state = WAIT;
            WAIT:    if (rsp_done || timed_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the granted request, count WAIT cycles, and register the response pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_f       <= 1'b0;
            owner_v       <= 1'b0;
            last_grant_v  <= 1'b1;
            req_write_q   <= 1'b0;
            req_addr_q    <= '0;
            req_wdata_q   <= '0;
            wait_cnt      <= '0;
            f_rsp_valid   <= 1'b0;
            v_rsp_valid   <= 1'b0;
            f_rsp_rdata   <= '0;
            v_rsp_rdata   <= '0;
            timeout_error <= 1'b0;
        end else begin
            f_rsp_valid <= 1'b0;
            v_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_f || grant_v) begin
                        owner_f     <= grant_f;
                        owner_v     <= grant_v;
                        req_write_q <= grant_v ? v_req_write : f_req_write;
                        req_addr_q  <= grant_v ? v_req_addr  : f_req_addr;
                        req_wdata_q <= grant_v ? v_req_wdata : f_req_wdata;
                    end
                end
                ISSUE: begin
                    if (m_req_ready) wait_cnt <= '0;
                end
                WAIT: begin
                    if (rsp_done || timed_out) begin
                        f_rsp_valid  <= owner_f;
                        v_rsp_valid  <= owner_v;
                        if (owner_f) f_rsp_rdata <= rsp_done ? m_rsp_rdata : '0;
                        if (owner_v) v_rsp_rdata <= rsp_done ? m_rsp_rdata : '0;
                        last_grant_v <= owner_v;
                        owner_f      <= 1'b0;
                        owner_v      <= 1'b0;
                        if (timed_out) timeout_error <= 1'b1;
                    end else if (wait_cnt != CNT_LIMIT) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a behavioural DRAM model, request driver tasks,
// a per-requester expected-response queue checked by a response monitor, and
// one task per scenario with inline timing/payload checks.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 64;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              f_req_valid = 1'b0, f_req_write = 1'b0;
    logic [ADDR_W-1:0] f_req_addr = '0;
    logic [DATA_W-1:0] f_req_wdata = '0;
    logic              f_req_ready, f_rsp_valid;
    logic [DATA_W-1:0] f_rsp_rdata;
    logic              v_req_valid = 1'b0, v_req_write = 1'b0;
    logic [ADDR_W-1:0] v_req_addr = '0;
    logic [DATA_W-1:0] v_req_wdata = '0;
    logic              v_req_ready, v_rsp_valid;
    logic [DATA_W-1:0] v_rsp_rdata;
    logic              m_req_valid, m_req_write;
    logic [ADDR_W-1:0] m_req_addr;
    logic [DATA_W-1:0] m_req_wdata;
    logic              m_req_ready = 1'b0, m_rsp_valid = 1'b0;
    logic [DATA_W-1:0] m_rsp_rdata = '0;
    logic              timeout_error;
    logic [1:0]        state_dbg;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .f_req_valid(f_req_valid), .f_req_write(f_req_write), .f_req_addr(f_req_addr),
        .f_req_wdata(f_req_wdata), .f_req_ready(f_req_ready),
        .f_rsp_valid(f_rsp_valid), .f_rsp_rdata(f_rsp_rdata),
        .v_req_valid(v_req_valid), .v_req_write(v_req_write), .v_req_addr(v_req_addr),
        .v_req_wdata(v_req_wdata), .v_req_ready(v_req_ready),
        .v_rsp_valid(v_rsp_valid), .v_rsp_rdata(v_rsp_rdata),
        .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
        .m_req_wdata(m_req_wdata), .m_req_ready(m_req_ready),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .timeout_error(timeout_error), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_f_q[$];
    logic [DATA_W-1:0] exp_v_q[$];

    // ---------------- DRAM model ----------------
    int                dram_stall  = 0;
    int                dram_delay  = 1;
    bit                dram_silent = 1'b0;
    bit                use_fixed   = 1'b0;
    bit                inject_stale = 1'b0;
    logic [DATA_W-1:0] fixed_data  = '0;
    int                hs_count    = 0;
    int                pending     = 0;
    logic [DATA_W-1:0] pend_data   = '0;

    function automatic logic [DATA_W-1:0] dram_data(input logic [ADDR_W-1:0] a);
        return {22'h2AAAAA, a, 21'h0F0F0};
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            m_rsp_valid = 1'b0;
            if (reset) begin
                pending     = 0;
                m_req_ready = 1'b0;
            end else begin
                if (pending > 0) begin
                    pending = pending - 1;
                    if (pending == 0) begin
                        m_rsp_valid = 1'b1;
                        m_rsp_rdata = pend_data;
                    end
                end
                if (inject_stale) begin
                    m_rsp_valid  = 1'b1;
                    m_rsp_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                    inject_stale = 1'b0;
                end
                m_req_ready = 1'b0;
                if (m_req_valid) begin
                    if (dram_stall > 0) begin
                        dram_stall = dram_stall - 1;
                    end else begin
                        m_req_ready = 1'b1;
                        hs_count    = hs_count + 1;
                        if (!dram_silent) begin
                            pending   = dram_delay;
                            pend_data = use_fixed ? fixed_data : dram_data(m_req_addr);
                        end
                    end
                end
            end
        end
    end

    // ---------------- response monitor (scoreboard) ----------------
    int f_rsp_cnt = 0, v_rsp_cnt = 0;
    int last_f_cyc = 0, last_v_cyc = 0;

    always begin
        logic [DATA_W-1:0] e;
        @(negedge clk);
        #1;
        if (!reset) begin
            if (f_rsp_valid) begin
                f_rsp_cnt++;
                last_f_cyc = cyc;
                n_checks++;
                if (exp_f_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL f_rsp_unexpected: got pulse data=%h, expected no pulse", f_rsp_rdata);
                end else begin
                    e = exp_f_q.pop_front();
                    if (f_rsp_rdata !== e) begin
                        n_fail++;
                        $display("FAIL f_rsp_data: got %h, expected %h", f_rsp_rdata, e);
                    end
                end
            end
            if (v_rsp_valid) begin
                v_rsp_cnt++;
                last_v_cyc = cyc;
                n_checks++;
                if (exp_v_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL v_rsp_unexpected: got pulse data=%h, expected no pulse", v_rsp_rdata);
                end else begin
                    e = exp_v_q.pop_front();
                    if (v_rsp_rdata !== e) begin
                        n_fail++;
                        $display("FAIL v_rsp_data: got %h, expected %h", v_rsp_rdata, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge. Presents a request, waits for ready, records the
    // expected response, and drops valid on the following negedge.
    task automatic send(input bit is_v, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_data,
                        output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        if (is_v) begin
            v_req_valid = 1'b1; v_req_write = wr; v_req_addr = addr; v_req_wdata = wdata;
        end else begin
            f_req_valid = 1'b1; f_req_write = wr; f_req_addr = addr; f_req_wdata = wdata;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if ((is_v && v_req_ready) || (!is_v && f_req_ready)) begin
                if (is_v) exp_v_q.push_back(exp_data);
                else      exp_f_q.push_back(exp_data);
                acc_cyc = cyc;
                done    = 1'b1;
            end
            @(negedge clk);
        end
        if (is_v) v_req_valid = 1'b0;
        else      f_req_valid = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL send_accept: got no ready within 100 cycles, expected acceptance (is_v=%0d addr=%h)", is_v, addr);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_f_q.size() != 0 || exp_v_q.size() != 0); i++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_f_q.size() != 0 || exp_v_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d f / %0d v responses outstanding, expected 0", exp_f_q.size(), exp_v_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        f_req_valid = 1'b0; v_req_valid = 1'b0;
        dram_stall = 0; dram_silent = 1'b0; dram_delay = 1; use_fixed = 1'b0;
        repeat (2) @(negedge clk);
        exp_f_q.delete(); exp_v_q.delete();
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if ({f_req_ready, v_req_ready, m_req_valid, f_rsp_valid, v_rsp_valid, timeout_error} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, expected 000000",
                {f_req_ready, v_req_ready, m_req_valid, f_rsp_valid, v_rsp_valid, timeout_error});
        end
        n_checks++;
        if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state_dbg); end
        n_checks++;
        if ({m_req_write, m_req_addr, m_req_wdata, f_rsp_rdata, v_rsp_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h, expected all zero", m_req_addr, m_req_wdata);
        end
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        int acc, c0;
        use_fixed = 1'b1; fixed_data = 64'hDEADBEEF_CAFEF00D; dram_delay = 1;
        c0 = cyc;
        send(1'b0, 1'b0, 21'h00100, '0, 64'hDEADBEEF_CAFEF00D, acc);
        n_checks++;
        if (acc !== c0) begin n_fail++; $display("FAIL single_accept_cycle: got %0d, expected %0d", acc, c0); end
        #1;
        n_checks++;
        if (m_req_valid !== 1'b1 || m_req_addr !== 21'h00100 || m_req_write !== 1'b0) begin
            n_fail++; $display("FAIL single_issue: got valid=%b addr=%h wr=%b, expected 1 00100 0", m_req_valid, m_req_addr, m_req_write);
        end
        @(negedge clk); #1;
        n_checks++;
        if (m_req_valid !== 1'b0 || f_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: got m_req_valid=%b f_rsp_valid=%b, expected 0 0", m_req_valid, f_rsp_valid);
        end
        @(negedge clk); #1;
        n_checks++;
        if (f_rsp_valid !== 1'b1 || f_rsp_rdata !== 64'hDEADBEEF_CAFEF00D || v_rsp_valid !== 1'b0 || cyc != acc + 3) begin
            n_fail++; $display("FAIL single_rsp: got f=%b data=%h v=%b cyc=+%0d, expected 1 deadbeefcafef00d 0 +3",
                f_rsp_valid, f_rsp_rdata, v_rsp_valid, cyc - acc);
        end
        use_fixed = 1'b0;
        drain();
    endtask

    task automatic test_round_robin();
        bit order[4];
        int gc[4];
        int g = 0;
        bit gf, gv, both;
        do_reset();
        both = 1'b0;
        f_req_addr = 21'h00200; v_req_addr = 21'h00300;
        f_req_write = 1'b0; v_req_write = 1'b0;
        f_req_valid = 1'b1; v_req_valid = 1'b1;
        for (int i = 0; i < 60 && g < 4; i++) begin
            #1;
            gf = f_req_ready; gv = v_req_ready;
            if (gf && gv) both = 1'b1;
            if (gf) begin exp_f_q.push_back(dram_data(f_req_addr)); order[g] = 1'b0; gc[g] = cyc; g++; end
            else if (gv) begin exp_v_q.push_back(dram_data(v_req_addr)); order[g] = 1'b1; gc[g] = cyc; g++; end
            @(negedge clk);
            if (gf) f_req_addr = f_req_addr + 21'd1;
            if (gv) v_req_addr = v_req_addr + 21'd1;
        end
        f_req_valid = 1'b0; v_req_valid = 1'b0;
        n_checks++;
        if (g != 4 || both) begin n_fail++; $display("FAIL rr_grants: got %0d grants dual=%b, expected 4 single", g, both); end
        n_checks++;
        if (g == 4 && {order[0], order[1], order[2], order[3]} !== 4'b0101) begin
            n_fail++; $display("FAIL rr_order: got %b (0=F), expected 0101", {order[0], order[1], order[2], order[3]});
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (g == 4 && gc[k+1] - gc[k] != 3) begin
                n_fail++; $display("FAIL rr_b2b_spacing%0d: got %0d cycles, expected 3", k, gc[k+1] - gc[k]);
            end
        end
        drain();
    endtask

    task automatic test_stall();
        int acc, h0, v0;
        h0 = hs_count; v0 = v_rsp_cnt;
        dram_stall = 5;
        send(1'b1, 1'b0, 21'h0ABCD, '0, dram_data(21'h0ABCD), acc);
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (m_req_valid !== 1'b1 || m_req_addr !== 21'h0ABCD || m_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got valid=%b addr=%h ready=%b, expected 1 0abcd 0", i, m_req_valid, m_req_addr, m_req_ready);
            end
            @(negedge clk);
        end
        drain();
        n_checks++;
        if (hs_count != h0 + 1 || v_rsp_cnt != v0 + 1) begin
            n_fail++; $display("FAIL stall_counts: got hs=%0d rsp=%0d, expected 1 1", hs_count - h0, v_rsp_cnt - v0);
        end
    endtask

    task automatic test_vec_write();
        int acc, f0, v0;
        f0 = f_rsp_cnt; v0 = v_rsp_cnt;
        send(1'b1, 1'b1, 21'h1FFFFF, 64'h0123456789ABCDEF, dram_data(21'h1FFFFF), acc);
        #1;
        n_checks++;
        if (m_req_valid !== 1'b1 || m_req_write !== 1'b1 || m_req_addr !== 21'h1FFFFF || m_req_wdata !== 64'h0123456789ABCDEF) begin
            n_fail++; $display("FAIL vwrite_payload: got v=%b wr=%b addr=%h wdata=%h, expected 1 1 1fffff 0123456789abcdef",
                m_req_valid, m_req_write, m_req_addr, m_req_wdata);
        end
        drain();
        n_checks++;
        if (v_rsp_cnt != v0 + 1 || f_rsp_cnt != f0) begin
            n_fail++; $display("FAIL vwrite_rsp: got v=%0d f=%0d pulses, expected 1 0", v_rsp_cnt - v0, f_rsp_cnt - f0);
        end
    endtask

    task automatic test_random();
        int acc;
        bit sv, wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        for (int i = 0; i < 8; i++) begin
            sv = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, 21'h1FFFFF));
            wd = {32'($urandom), 32'($urandom)};
            dram_delay = $urandom_range(1, TO - 1);
            dram_stall = $urandom_range(0, 3);
            send(sv, wr, a, wd, dram_data(a), acc);
            drain();
        end
        dram_delay = 1;
        n_checks++;
        if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL random_no_timeout: got %b, expected 0", timeout_error); end
    endtask

    task automatic test_rsp_at_limit();
        int acc;
        dram_delay = TO;
        send(1'b0, 1'b0, 21'h00400, '0, dram_data(21'h00400), acc);
        drain();
        dram_delay = 1;
        n_checks++;
        if (timeout_error !== 1'b0 || last_f_cyc != acc + TO + 2) begin
            n_fail++; $display("FAIL limit_rsp: got err=%b rsp at +%0d, expected 0 +%0d", timeout_error, last_f_cyc - acc, TO + 2);
        end
    endtask

    task automatic test_timeout();
        int acc, v0;
        dram_silent = 1'b1;
        send(1'b0, 1'b0, 21'h00500, '0, '0, acc);
        repeat (TO) @(negedge clk);
        #1;
        n_checks++;
        if (f_rsp_valid !== 1'b0 || timeout_error !== 1'b0) begin
            n_fail++; $display("FAIL timeout_early: got rsp=%b err=%b at +%0d, expected 0 0", f_rsp_valid, timeout_error, cyc - acc);
        end
        @(negedge clk); #1;
        n_checks++;
        if (f_rsp_valid !== 1'b1 || f_rsp_rdata !== '0 || timeout_error !== 1'b1 || v_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fire: got rsp=%b data=%h err=%b at +%0d, expected 1 0 1 +%0d",
                f_rsp_valid, f_rsp_rdata, timeout_error, cyc - acc, TO + 2);
        end
        dram_silent = 1'b0;
        @(negedge clk);
        v0 = v_rsp_cnt;
        send(1'b1, 1'b0, 21'h00600, '0, dram_data(21'h00600), acc);
        drain();
        n_checks++;
        if (timeout_error !== 1'b1 || v_rsp_cnt != v0 + 1) begin
            n_fail++; $display("FAIL timeout_after: got err=%b pulses=%0d, expected 1 1", timeout_error, v_rsp_cnt - v0);
        end
    endtask

    task automatic test_reset_mid();
        int acc, c0;
        dram_silent = 1'b1;
        send(1'b1, 1'b0, 21'h00700, '0, '0, acc);
        @(negedge clk); #1;
        n_checks++;
        if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL midrst_in_wait: got state %0d, expected 2", state_dbg); end
        #1;
        f_req_valid = 1'b1; v_req_valid = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({f_req_ready, v_req_ready, m_req_valid, f_rsp_valid, v_rsp_valid, timeout_error, state_dbg} !== 8'b0 ||
            m_req_addr !== '0 || m_req_wdata !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got rdy=%b%b mv=%b rsp=%b%b err=%b st=%0d addr=%h, expected all 0",
                f_req_ready, v_req_ready, m_req_valid, f_rsp_valid, v_rsp_valid, timeout_error, state_dbg, m_req_addr);
        end
        exp_f_q.delete(); exp_v_q.delete();
        f_req_valid = 1'b0; v_req_valid = 1'b0;
        dram_silent = 1'b0;
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); #2 inject_stale = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if (state_dbg !== 2'd0 || f_rsp_valid !== 1'b0 || v_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stale: got state=%0d rsp=%b%b, expected 0 00", state_dbg, f_rsp_valid, v_rsp_valid);
        end
        @(negedge clk);
        v_req_valid = 1'b1; v_req_write = 1'b0; v_req_addr = 21'h00800;
        c0 = cyc;
        send(1'b0, 1'b0, 21'h00900, '0, dram_data(21'h00900), acc);
        n_checks++;
        if (acc !== c0) begin n_fail++; $display("FAIL midrst_tie: fetch accepted at +%0d, expected +0", acc - c0); end
        send(1'b1, 1'b0, 21'h00800, '0, dram_data(21'h00800), acc);
        drain();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_stall();
        test_vec_write();
        test_random();
        test_rsp_at_limit();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by time limit, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
